cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Multi-cycle control FSM for the 9-bit, 8-register CPU datapath. It sequences the register file, the A/G accumulator pair, the ALU and the DIN bus driver.
- Latches a 9-bit instruction word (opcode[8:6], rx[5:3], ry[2:0]) on a run request. Then asserts one-hot register enables and bus-select strobes per time step until done.
- Opcodes: LOAD=000, MOVE=001, ADD=010, XOR=011, TERM=100; 101–111 are illegal.

Parameters:
- INSTR_W, 9, instruction word width (field positions fixed as above; other values unsupported)
- CNT_W, 8, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- run  in  1  start request; sampled only in IDLE
- instr  in  INSTR_W  instruction word, captured when run accepted
- ir_out  out  INSTR_W  latched instruction register
- r_in  out  8  one-hot register write enable (bit n = Rn)
- r_out  out  8  one-hot register bus drive (bit n = Rn)
- din_out  out  1  drive DIN onto bus
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- g_out  out  1  drive G onto bus
- alu_op  out  1  0 = add, 1 = xor (valid whenever g_in=1)
- busy  out  1  instruction in progress (state T1..T3)
- done  out  1  one-cycle pulse in final step of each instruction
- illegal  out  1  one-cycle pulse with done for opcodes 101–111
- halted  out  1  TERM executed; sticky until reset
- retired  out  CNT_W  count of completed legal instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, resetn=0): state=IDLE, ir_out=0, retired=0, halted=0; all strobes, busy, done and illegal = 0. Deassertion takes effect on the next clk edge.
- States: IDLE, T1, T2, T3, HALT. State register and IR are flops; strobes are combinational from state + ir_out only (no instr/run paths to strobes).
- IDLE:
  - run=1 at an edge → ir_out<=instr, next state T1.
  - run=0 → stay in IDLE.
  - No strobes asserted in IDLE.
- T1 actions by opcode:
  - LOAD: din_out=1, r_in[rx]=1, done=1 → IDLE.
  - MOVE: r_out[ry]=1, r_in[rx]=1, done=1 → IDLE. rx==ry is legal: same enables, no special case.
  - ADD/XOR: r_out[rx]=1, a_in=1 → T2.
  - TERM: done=1 → HALT.
  - Illegal: done=1, illegal=1, no enables → IDLE.
- T2 (ADD/XOR only): r_out[ry]=1, g_in=1, alu_op=opcode[0] → T3.
- T3 (ADD/XOR only): g_out=1, r_in[rx]=1, done=1 → IDLE.
- HALT: halted=1, no strobes, busy=0, run ignored; exit only via reset.
- Latency from run-accept edge: LOAD/MOVE/TERM/illegal done in the 1st cycle after the edge; ADD/XOR done in the 3rd.
- Back-to-back: run held high with done → the next instruction is accepted at the edge leaving T-final → IDLE. One IDLE cycle minimum between instructions.
- run while busy: ignored; ir_out must not change.
- retired increments on the edge ending any cycle where done=1 and illegal=0 (TERM counts). Wraps 2^CNT_W−1 → 0.
- Invariants:
  - r_out and {din_out, g_out} are mutually exclusive: at most one bus driver per cycle.
  - r_in is one-hot or zero.
- Reset mid-instruction (any T-state or HALT): immediate return to reset values; no partial write strobes after resetn falls.

Test Plan:
- Reset then LOAD R3 (instr=9'b000_011_000, run 1 cycle) → next cycle din_out=1, r_in=8'h08, done=1; then IDLE; retired=1.
- ADD R1,R6 (9'b010_001_110) → T1: r_out=8'h02, a_in=1; T2: r_out=8'h40, g_in=1, alu_op=0; T3: g_out=1, r_in=8'h02, done=1; busy high exactly 3 cycles.
- XOR R5,R5 with run held high and instr changed to MOVE R0,R2 during T2 → alu_op=1 in T2, ir_out unchanged until T3. After one IDLE cycle, MOVE executes with r_out=8'h04, r_in=8'h01.
- Opcode 110 → done=1, illegal=1, r_in=0, r_out=0; retired unchanged. TERM (9'b100_000_000) → done, halted=1 persists; subsequent run pulses produce no strobes; resetn=0 clears halted.
- Assert resetn=0 asynchronously mid-T2 of ADD → all outputs 0 before the next clk edge; no r_in pulse occurs.
- Retire 256 legal LOADs → retired wraps 255 → 0; strobe exclusivity assertion holds throughout.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM for the 9-bit, 8-register CPU. Done comes 1 cycle after run is accepted
// for LOAD/MOVE/TERM/illegal and 3 cycles after for ADD/XOR; run is only sampled in IDLE.
module cpu_control_sequencer #(
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir_out,
  output logic [7:0]         r_in,
  output logic [7:0]         r_out,
  output logic               din_out,
  output logic               a_in,
  output logic               g_in,
  output logic               g_out,
  output logic               alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_TERM = 3'b100;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [2:0] opcode;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;

  assign opcode = ir_q[8:6];
  assign rx_oh  = 8'b1 << ir_q[5:3];
  assign ry_oh  = 8'b1 << ir_q[2:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Strobes depend only on state_q and ir_q, so reset silences them immediately.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    r_in    = '0;
    r_out   = '0;
    din_out = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    alu_op  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    halted  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = instr;
          state_d = S_T1;
        end
      end
      S_T1: begin
        busy = 1'b1;
        unique case (opcode)
          OP_LOAD: begin
            din_out = 1'b1;
            r_in    = rx_oh;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_MOVE: begin
            r_out   = ry_oh;
            r_in    = rx_oh;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_ADD, OP_XOR: begin
            r_out   = rx_oh;
            a_in    = 1'b1;
            state_d = S_T2;
          end
          OP_TERM: begin
            done    = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_T2: begin
        busy    = 1'b1;
        r_out   = ry_oh;
        g_in    = 1'b1;
        alu_op  = opcode[0];
        state_d = S_T3;
      end
      S_T3: begin
        busy    = 1'b1;
        g_out   = 1'b1;
        r_in    = rx_oh;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    retired_d = retired_q;
    if (done && !illegal) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  assign ir_out  = ir_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: inputs change and outputs are checked on the falling edge.
module tb_cpu_control_sequencer;

  logic       clk;
  logic       resetn;
  logic       run;
  logic [8:0] instr;
  logic [8:0] ir_out;
  logic [7:0] r_in, r_out;
  logic       din_out, a_in, g_in, g_out, alu_op;
  logic       busy, done, illegal, halted;
  logic [7:0] retired;

  int n_chk  = 0;
  int n_pass = 0;
  int n_viol = 0;

  cpu_control_sequencer #(.INSTR_W(9), .CNT_W(8)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .instr   (instr),
    .ir_out  (ir_out),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .halted  (halted),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-driver exclusivity and one-hot register enables, watched every cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (!$onehot0(r_out) || !$onehot0(r_in) ||
          ((|r_out) && (din_out || g_out)) || (din_out && g_out))
        n_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Packs all per-cycle strobes so one comparison covers a whole step.
  function automatic logic [31:0] pk(input logic [7:0] ri, input logic [7:0] ro,
                                     input logic din, input logic a, input logic gi,
                                     input logic go, input logic op, input logic bz,
                                     input logic dn, input logic il, input logic hl);
    return {7'd0, ri, ro, din, a, gi, go, op, bz, dn, il, hl};
  endfunction

  function automatic logic [31:0] obs();
    return pk(r_in, r_out, din_out, a_in, g_in, g_out, alu_op, busy, done, illegal, halted);
  endfunction

  localparam logic [31:0] IDLE_V = 32'd0;

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    instr  = '0;
    step();
    chk("reset_strobes", obs(), IDLE_V);
    chk("reset_ir", 32'(ir_out), 32'h0);
    chk("reset_retired", 32'(retired), 32'd0);
    resetn = 1'b1;
    step();
    chk("idle_no_run", obs(), IDLE_V);

    // LOAD R3
    instr = 9'b000_011_000; run = 1'b1;
    step(); run = 1'b0;
    chk("load_t1", obs(), pk(8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    step();
    chk("load_idle", obs(), IDLE_V);
    chk("load_retired", 32'(retired), 32'd1);
    chk("load_ir", 32'(ir_out), 32'h018);

    // ADD R1,R6
    instr = 9'b010_001_110; run = 1'b1;
    step(); run = 1'b0;
    chk("add_t1", obs(), pk(8'h00, 8'h02, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    step();
    chk("add_t2", obs(), pk(8'h00, 8'h40, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    step();
    chk("add_t3", obs(), pk(8'h02, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    step();
    chk("add_idle", obs(), IDLE_V);
    chk("add_retired", 32'(retired), 32'd2);

    // XOR R5,R5 with run held; instr swapped to MOVE R0,R2 while busy
    instr = 9'b011_101_101; run = 1'b1;
    step();
    chk("xor_t1", obs(), pk(8'h00, 8'h20, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    instr = 9'b001_000_010;
    step();
    chk("xor_t2", obs(), pk(8'h00, 8'h20, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    chk("xor_t2_ir", 32'(ir_out), 32'h0ED);
    step();
    chk("xor_t3", obs(), pk(8'h20, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    chk("xor_t3_ir", 32'(ir_out), 32'h0ED);
    step();
    chk("b2b_idle_gap", obs(), IDLE_V);
    chk("xor_retired", 32'(retired), 32'd3);
    step(); run = 1'b0;
    chk("move_t1", obs(), pk(8'h01, 8'h04, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    chk("move_ir", 32'(ir_out), 32'h042);
    step();
    chk("move_retired", 32'(retired), 32'd4);

    // Illegal opcode 110
    instr = 9'b110_000_000; run = 1'b1;
    step(); run = 1'b0;
    chk("illegal_t1", obs(), pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    step();
    chk("illegal_idle", obs(), IDLE_V);
    chk("illegal_retired", 32'(retired), 32'd4);

    // 251 back-to-back LOADs into R7 reach 255, one more wraps to 0
    instr = 9'b000_111_000; run = 1'b1;
    for (int i = 0; i < 251; i++) begin
      step();
      step();
    end
    run = 1'b0;
    chk("cnt_255", 32'(retired), 32'd255);
    step();
    chk("cnt_hold", 32'(retired), 32'd255);
    run = 1'b1;
    step(); run = 1'b0;
    chk("load_r7_t1", obs(), pk(8'h80, 8'h00, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    step();
    chk("cnt_wrap", 32'(retired), 32'd0);

    // Async reset in the middle of T2 of ADD R1,R6
    instr = 9'b010_001_110; run = 1'b1;
    step(); run = 1'b0;
    step();
    chk("rst_pre_t2", obs(), pk(8'h00, 8'h40, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_strobes", obs(), IDLE_V);
    chk("rst_async_ir", 32'(ir_out), 32'h0);
    step();
    chk("rst_no_rin", obs(), IDLE_V);
    resetn = 1'b1;
    step();
    chk("rst_after_idle", obs(), IDLE_V);

    // TERM then halted sticks and ignores run
    instr = 9'b100_000_000; run = 1'b1;
    step(); run = 1'b0;
    chk("term_t1", obs(), pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step();
    chk("halt_state", obs(), pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("term_retired", 32'(retired), 32'd1);
    instr = 9'b000_001_000; run = 1'b1;
    step();
    step(); run = 1'b0;
    chk("halt_ignores_run", obs(), pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("halt_ir", 32'(ir_out), 32'h100);
    #2 resetn = 1'b0;
    #1;
    chk("halt_cleared", obs(), IDLE_V);
    chk("halt_rst_retired", 32'(retired), 32'd0);
    step();
    resetn = 1'b1;
    step();

    chk("bus_exclusive", 32'(n_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
